// File: rtl/hdmi_pattern_gen_if.sv
// Avalon-ST video source bundle between the pattern generator and the HDMI core sink.
// The master drives the pixel and framing flags; the slave returns ready (readyLatency 0).
interface hdmi_pattern_gen_if #(
    parameter int BPC = 8
);
    logic               src_valid;
    logic               src_ready;
    logic [3*BPC-1:0]   src_data;
    logic               src_sop;
    logic               src_eop;

    modport master (
        output src_valid,
        output src_data,
        output src_sop,
        output src_eop,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        input  src_sop,
        input  src_eop,
        output src_ready
    );
endinterface

// File: rtl/hdmi_pattern_gen.sv
// Back-pressure aware test-pattern source: solid, bands, bars, checker and ramp frames.
//
// state | meaning
// IDLE  | no frame in flight, waiting for enable with non-zero dimensions
// RUN   | presenting pixels of a latched frame, advancing on each accepted transfer
module hdmi_pattern_gen #(
    parameter int BPC         = 8,
    parameter int DIM_W       = 11,
    parameter int N_BARS_LOG2 = 3,
    parameter int CHECK_LOG2  = 5
) (
    input  logic               clk_st,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [2:0]         mode,
    input  logic [3*BPC-1:0]   solid_rgb,
    input  logic [DIM_W-1:0]   horz,
    input  logic [DIM_W-1:0]   vert,
    hdmi_pattern_gen_if.master src,
    output logic               frame_done,
    output logic [15:0]        frame_cnt
);

    localparam logic [DIM_W-1:0]       DIM_ONE = DIM_W'(1);
    localparam logic [N_BARS_LOG2-1:0] IDX_ONE = N_BARS_LOG2'(1);
    localparam logic [N_BARS_LOG2-1:0] IDX_MAX = '1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t state;

    logic [DIM_W-1:0]       f_horz, f_vert;
    logic [2:0]             f_mode;
    logic [3*BPC-1:0]       f_rgb;
    logic [BPC-1:0]         f_blue;
    logic [DIM_W-1:0]       x, y, bcnt;
    logic [N_BARS_LOG2-1:0] bidx;

    logic                   start_ok, accept, last_px, do_start, last_x, next_eop;
    logic                   band_step, band_clr;
    logic [DIM_W-1:0]       nx, ny, nbcnt, bsz;
    logic [N_BARS_LOG2-1:0] nbidx;
    logic [15:0]            cnt_inc;
    logic [2:0]             p_mode, p_bar;
    logic [3*BPC-1:0]       p_rgb, pix;
    logic [BPC-1:0]         p_x, p_y, p_blue;
    logic                   p_chk, p_eop;

    always_comb begin
        start_ok = enable && (horz != '0) && (vert != '0);
        accept   = (state == RUN) && src.src_valid && src.src_ready;
        last_px  = accept && src.src_eop;
        do_start = ((state == IDLE) || last_px) && start_ok;
        cnt_inc  = frame_cnt + 16'd1;

        last_x   = (x == f_horz - DIM_ONE);
        nx       = last_x ? '0 : x + DIM_ONE;
        ny       = last_x ? y + DIM_ONE : y;
        next_eop = (nx == f_horz - DIM_ONE) && (ny == f_vert - DIM_ONE);

        // Bars restart every line; bands only advance on line wrap.
        bsz       = (f_mode == 3'd1) ? (f_vert >> N_BARS_LOG2) : (f_horz >> N_BARS_LOG2);
        band_clr  = (f_mode == 3'd2) && last_x;
        band_step = (f_mode == 3'd2) || ((f_mode == 3'd1) && last_x);
        nbcnt     = bcnt;
        nbidx     = bidx;
        if (band_clr) begin
            nbcnt = '0;
            nbidx = '0;
        end else if (band_step && (bsz != '0)) begin
            if (bcnt + DIM_ONE == bsz) begin
                nbcnt = '0;
                if (bidx != IDX_MAX) nbidx = bidx + IDX_ONE;
            end else begin
                nbcnt = bcnt + DIM_ONE;
            end
        end

        // A frame start takes its pixel from the live inputs, otherwise from the latched frame.
        if (do_start) begin
            p_mode = mode;
            p_rgb  = solid_rgb;
            p_x    = '0;
            p_y    = '0;
            p_chk  = 1'b0;
            p_bar  = 3'd0;
            p_blue = (state == RUN) ? cnt_inc[BPC-1:0] : frame_cnt[BPC-1:0];
            p_eop  = (horz == DIM_ONE) && (vert == DIM_ONE);
        end else begin
            p_mode = f_mode;
            p_rgb  = f_rgb;
            p_x    = nx[BPC-1:0];
            p_y    = ny[BPC-1:0];
            p_chk  = nx[CHECK_LOG2] ^ ny[CHECK_LOG2];
            p_bar  = 3'(nbidx);
            p_blue = f_blue;
            p_eop  = next_eop;
        end

        case (p_mode)
            3'd0:       pix = p_rgb;
            3'd1, 3'd2: pix = {{BPC{p_bar[2]}}, {BPC{p_bar[1]}}, {BPC{p_bar[0]}}};
            3'd3:       pix = {(3*BPC){p_chk}};
            3'd4:       pix = {p_blue, p_y, p_x};
            default:    pix = '0;
        endcase
    end

    always_ff @(posedge clk_st or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            f_horz        <= '0;
            f_vert        <= '0;
            f_mode        <= '0;
            f_rgb         <= '0;
            f_blue        <= '0;
            x             <= '0;
            y             <= '0;
            bcnt          <= '0;
            bidx          <= '0;
            src.src_valid <= 1'b0;
            src.src_data  <= '0;
            src.src_sop   <= 1'b0;
            src.src_eop   <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            if (last_px) begin
                frame_cnt  <= cnt_inc;
                frame_done <= 1'b1;
            end

            if (do_start) begin
                state         <= RUN;
                f_horz        <= horz;
                f_vert        <= vert;
                f_mode        <= mode;
                f_rgb         <= solid_rgb;
                f_blue        <= p_blue;
                x             <= '0;
                y             <= '0;
                bcnt          <= '0;
                bidx          <= '0;
                src.src_valid <= 1'b1;
                src.src_data  <= pix;
                src.src_sop   <= 1'b1;
                src.src_eop   <= p_eop;
            end else if (last_px) begin
                state         <= IDLE;
                src.src_valid <= 1'b0;
                src.src_sop   <= 1'b0;
                src.src_eop   <= 1'b0;
            end else if (accept) begin
                x             <= nx;
                y             <= ny;
                bcnt          <= nbcnt;
                bidx          <= nbidx;
                src.src_data  <= pix;
                src.src_sop   <= 1'b0;
                src.src_eop   <= next_eop;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Directed bench for hdmi_pattern_gen: each pattern, back-pressure, continuous frames,
// mid-frame disturbance and asynchronous reset, with hand-computed expected pixels.
module tb_hdmi_pattern_gen;

    logic        clk_st = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [10:0] horz = 11'd0;
    logic [10:0] vert = 11'd0;
    logic        frame_done;
    logic [15:0] frame_cnt;

    hdmi_pattern_gen_if #(.BPC(8)) st();

    hdmi_pattern_gen #(
        .BPC(8), .DIM_W(11), .N_BARS_LOG2(3), .CHECK_LOG2(1)
    ) dut (
        .clk_st     (clk_st),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .solid_rgb  (solid_rgb),
        .horz       (horz),
        .vert       (vert),
        .src        (st),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk_st = ~clk_st;

    logic [23:0] BAR [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                             24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};

    int n_tests = 0;
    int n_fail = 0;
    logic [23:0] got_d[$], exp_d[$];
    logic        got_s[$], got_e[$], exp_s[$], exp_e[$];
    int stall_bad, gaps, done_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_st);
        #1;
    endtask

    task automatic expect_px(input logic [23:0] d, input logic s, input logic e);
        exp_d.push_back(d);
        exp_s.push_back(s);
        exp_e.push_back(e);
    endtask

    // Load a new frame configuration and pulse enable for one edge; keep decides enable afterwards.
    task automatic start(input logic [2:0] m, input logic [10:0] h, input logic [10:0] v,
                         input logic [23:0] rgb, input logic keep);
        mode = m; horz = h; vert = v; solid_rgb = rgb; enable = 1'b1;
        tick();
        enable = keep;
    endtask

    // Records n transfers; at transfer count drop_at drops enable and disturbs mode/horz.
    task automatic collect(input int n, input bit rnd, input int drop_at,
                           input logic [2:0] new_mode, input logic [10:0] new_horz);
        int guard = 0;
        bit held = 1'b0;
        logic [23:0] hd = '0;
        logic hs = 1'b0, he = 1'b0;
        got_d.delete(); got_s.delete(); got_e.delete();
        stall_bad = 0; gaps = 0; done_seen = 0;
        while (got_d.size() < n && guard < 4000) begin
            if (got_d.size() == drop_at) begin
                enable = 1'b0; mode = new_mode; horz = new_horz;
            end
            st.src_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (held && (st.src_valid !== 1'b1 || st.src_data !== hd ||
                         st.src_sop !== hs || st.src_eop !== he)) stall_bad++;
            if (st.src_valid !== 1'b1) gaps++;
            if (frame_done === 1'b1) done_seen++;
            held = st.src_valid && !st.src_ready;
            hd = st.src_data; hs = st.src_sop; he = st.src_eop;
            if (st.src_valid && st.src_ready) begin
                got_d.push_back(st.src_data);
                got_s.push_back(st.src_sop);
                got_e.push_back(st.src_eop);
            end
            tick();
            guard++;
        end
        st.src_ready = 1'b0;
        check("collect_in_budget", 32'(guard < 4000), 32'd1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
        foreach (exp_d[i]) begin
            if (i < got_d.size()) begin
                check($sformatf("%s_data[%0d]", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
                check($sformatf("%s_sop[%0d]", tag, i), 32'(got_s[i]), 32'(exp_s[i]));
                check($sformatf("%s_eop[%0d]", tag, i), 32'(got_e[i]), 32'(exp_e[i]));
            end
        end
        exp_d.delete(); exp_s.delete(); exp_e.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st.src_ready = 1'b0;
        // Reset held with enable high: everything stays quiet.
        reset_n = 1'b0; enable = 1'b1; mode = 3'd0; horz = 11'd4; vert = 11'd2;
        solid_rgb = 24'h123456;
        repeat (3) tick();
        check("rst_valid", 32'(st.src_valid), 32'd0);
        check("rst_data", 32'(st.src_data), 32'd0);
        check("rst_sop", 32'(st.src_sop), 32'd0);
        check("rst_eop", 32'(st.src_eop), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);

        reset_n = 1'b1;
        tick();
        check("first_valid", 32'(st.src_valid), 32'd1);
        check("first_sop", 32'(st.src_sop), 32'd1);
        check("first_data", 32'(st.src_data), 32'h123456);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) expect_px(24'h123456, i == 0, i == 7);
        collect(8, 1'b0, -1, 3'd0, 11'd4);
        compare("solid");
        check("solid_done", 32'(frame_done), 32'd1);
        check("solid_cnt", 32'(frame_cnt), 32'd1);
        check("solid_idle", 32'(st.src_valid), 32'd0);
        tick();
        check("solid_done_pulse", 32'(frame_done), 32'd0);

        // Vertical bars 16x1: eight bars of two pixels each.
        start(3'd2, 11'd16, 11'd1, 24'h0, 1'b0);
        for (int i = 0; i < 16; i++) expect_px(BAR[i / 2], i == 0, i == 15);
        collect(16, 1'b0, -1, 3'd2, 11'd16);
        compare("vbars");
        check("vbars_cnt", 32'(frame_cnt), 32'd2);

        // Horizontal bands 2x10: band size 1, index saturates at 7.
        start(3'd1, 11'd2, 11'd10, 24'h0, 1'b0);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 2; c++)
                expect_px(BAR[(r > 7) ? 7 : r], r == 0 && c == 0, r == 9 && c == 1);
        collect(20, 1'b0, -1, 3'd1, 11'd2);
        compare("hbands");
        check("hbands_cnt", 32'(frame_cnt), 32'd3);

        // Ramp 8x4 under random back-pressure; blue is the completed-frame count (3).
        start(3'd4, 11'd8, 11'd4, 24'h0, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                expect_px({8'd3, 8'(r), 8'(c)}, r == 0 && c == 0, r == 3 && c == 7);
        collect(32, 1'b1, -1, 3'd4, 11'd8);
        compare("ramp");
        check("ramp_stall_stable", 32'(stall_bad), 32'd0);
        check("ramp_cnt", 32'(frame_cnt), 32'd4);

        // Checker 4x4, three back-to-back frames, enable dropped during the third.
        start(3'd3, 11'd4, 11'd4, 24'h0, 1'b1);
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    expect_px((((c / 2) % 2) != ((r / 2) % 2)) ? 24'hFFFFFF : 24'h0,
                              r == 0 && c == 0, r == 3 && c == 3);
        collect(48, 1'b0, 40, 3'd3, 11'd4);
        compare("checker");
        check("checker_gaps", 32'(gaps), 32'd0);
        check("checker_done_pulses", 32'(done_seen), 32'd2);
        check("checker_last_done", 32'(frame_done), 32'd1);
        check("checker_cnt", 32'(frame_cnt), 32'd7);
        check("checker_idle", 32'(st.src_valid), 32'd0);

        // Disturbance: enable, mode and horz all change at pixel 5; frame must be unaffected.
        start(3'd2, 11'd16, 11'd1, 24'hABCDEF, 1'b1);
        for (int i = 0; i < 16; i++) expect_px(BAR[i / 2], i == 0, i == 15);
        collect(16, 1'b0, 5, 3'd0, 11'd4);
        compare("disturb");
        check("disturb_idle", 32'(st.src_valid), 32'd0);
        check("disturb_cnt", 32'(frame_cnt), 32'd8);

        // Bars with band size 0 (horz 4 >> 3): index stays 0, all black.
        start(3'd2, 11'd4, 11'd1, 24'h0, 1'b0);
        for (int i = 0; i < 4; i++) expect_px(24'h0, i == 0, i == 3);
        collect(4, 1'b0, -1, 3'd2, 11'd4);
        compare("band0");

        // 1x1 frame: sop and eop on the same pixel.
        start(3'd0, 11'd1, 11'd1, 24'h00A5C3, 1'b0);
        check("one_sop", 32'(st.src_sop), 32'd1);
        check("one_eop", 32'(st.src_eop), 32'd1);
        expect_px(24'h00A5C3, 1'b1, 1'b1);
        collect(1, 1'b0, -1, 3'd0, 11'd1);
        compare("one");
        check("one_cnt", 32'(frame_cnt), 32'd10);

        // Asynchronous reset mid-frame.
        start(3'd0, 11'd4, 11'd2, 24'h111111, 1'b1);
        collect(3, 1'b0, -1, 3'd0, 11'd4);
        #4;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(st.src_valid), 32'd0);
        check("arst_data", 32'(st.src_data), 32'd0);
        check("arst_sop", 32'(st.src_sop), 32'd0);
        check("arst_eop", 32'(st.src_eop), 32'd0);
        check("arst_done", 32'(frame_done), 32'd0);
        check("arst_cnt", 32'(frame_cnt), 32'd0);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("arst_stays_idle", 32'(st.src_valid), 32'd0);
        check("arst_no_done", 32'(frame_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
